// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Row/column patterns are active-low, one bit per line.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HOLD
   } state_e;

   localparam logic [3:0] KEY_ADD   = 4'hA;
   localparam logic [3:0] ROW_RESET = 4'b1110;

   function automatic logic [3:0] rotate_row(input logic [3:0] row);
      return {row[2:0], row[3]};
   endfunction

   // Index of the (single) zero bit in an active-low pattern.
   function automatic logic [1:0] enc_low(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!v[i]) idx = i[1:0];
      end
      return idx;
   endfunction

   function automatic logic is_single(input logic [3:0] col);
      logic [3:0] a;
      a = ~col;
      return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the key/add outputs consumed by the digit-entry stage.
// The scanner is the master; the keypad/consumer side is the slave.
interface keypad_scan_if;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;
   logic       add;

   modport master (
      input  col_n,
      output row_n,
      output key,
      output key_valid,
      output key_held,
      output add
   );

   modport slave (
      output col_n,
      input  row_n,
      input  key,
      input  key_valid,
      input  key_held,
      input  add
   );
endinterface

// File: rtl/keypad_tick.sv
// Scan prescaler: one-cycle tick every SCAN_DIV clocks, setting the row dwell time.
module keypad_tick #(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(SCAN_DIV - 1));

   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row drive, column synchronizer, press/release debounce,
// one-cycle key strobe and the '+'-toggled add-mode level.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.master kp
);

   localparam int CW = $clog2(DEBOUNCE_CNT + 1);

   logic          tick;
   logic [3:0]    col_p0_q, col_p1_q;
   logic [3:0]    col_s;
   state_e        state_q, state_d;
   logic [3:0]    row_q, row_d;
   logic [3:0]    code_q, code_d;
   logic [3:0]    pat_q, pat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rel_q, rel_d;
   logic [3:0]    key_q, key_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;
   logic          add_q, add_d;
   logic          accept;

   keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .tick_o(tick)
   );

   // stage p0/p1: two-flop synchronizer for the asynchronous columns
   always_ff @(posedge clk) begin
      if (rst) begin
         col_p0_q <= 4'b1111;
         col_p1_q <= 4'b1111;
      end else begin
         col_p0_q <= kp.col_n;
         col_p1_q <= col_p0_q;
      end
   end

   assign col_s = col_p1_q;

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      code_d      = code_q;
      pat_d       = pat_q;
      cnt_d       = cnt_q;
      rel_d       = rel_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      add_d       = add_q;
      accept      = 1'b0;

      case (state_q)
         SCAN: begin
            if (tick) begin
               if (is_single(col_s)) begin
                  code_d = {enc_low(row_q), enc_low(col_s)};
                  pat_d  = col_s;
                  cnt_d  = CW'(1);
                  if (DEBOUNCE_CNT == 1) accept  = 1'b1;
                  else                   state_d = DEBOUNCE;
               end else begin
                  row_d = rotate_row(row_q);
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (col_s == pat_q) begin
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q + CW'(1) == CW'(DEBOUNCE_CNT)) accept = 1'b1;
               end else begin
                  state_d = SCAN;
                  row_d   = rotate_row(row_q);
                  cnt_d   = '0;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               if (col_s == 4'b1111) begin
                  if (rel_q + CW'(1) == CW'(DEBOUNCE_CNT)) begin
                     state_d    = SCAN;
                     row_d      = rotate_row(row_q);
                     rel_d      = '0;
                     cnt_d      = '0;
                     key_held_d = 1'b0;
                  end else begin
                     rel_d = rel_q + CW'(1);
                  end
               end else begin
                  rel_d = '0;
               end
            end
         end
         default: state_d = SCAN;
      endcase

      // Accept is shared by the immediate (DEBOUNCE_CNT==1) and debounced paths.
      if (accept) begin
         state_d     = HOLD;
         key_d       = code_d;
         key_valid_d = 1'b1;
         key_held_d  = 1'b1;
         rel_d       = '0;
         if (code_d == KEY_ADD) add_d = ~add_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCAN;
         row_q       <= ROW_RESET;
         cnt_q       <= '0;
         rel_q       <= '0;
         key_q       <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         add_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         rel_q       <= rel_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         add_q       <= add_d;
      end
   end

   // Latched code/pattern are only read after being written on detection.
   always_ff @(posedge clk) begin
      code_q <= code_d;
      pat_q  <= pat_d;
   end

   assign kp.row_n     = row_q;
   assign kp.key       = key_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;
   assign kp.add       = add_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// behavioural 4x4 key matrix tied to the row drive.
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pressed = 16'h0000;

   int          checks = 0;
   int          passes = 0;
   int          vcount = 0;
   logic [3:0]  last_key = 4'h0;
   logic        held_at_pulse = 1'b0;

   always #5 clk = ~clk;

   keypad_scan_if kp_if ();

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk(clk),
      .rst(rst),
      .kp (kp_if)
   );

   function automatic logic [3:0] col_fn(input logic [15:0] p, input logic [3:0] r);
      logic [3:0] c;
      c = 4'b1111;
      for (int i = 0; i < 16; i++) begin
         if (p[i] && !r[i / 4]) c[i % 4] = 1'b0;
      end
      return c;
   endfunction

   assign kp_if.col_n = col_fn(pressed, kp_if.row_n);

   always @(posedge clk) begin
      #1;
      if (kp_if.key_valid === 1'b1) begin
         vcount++;
         last_key      = kp_if.key;
         held_at_pulse = kp_if.key_held;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_row_entry(input logic [3:0] target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (kp_if.row_n !== target) break;
         @(negedge clk);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (kp_if.row_n === target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pressed = 16'h0000;
      step(2);
      checks++; if (kp_if.row_n !== 4'b1110) $display("FAIL reset_row got=%b exp=1110", kp_if.row_n); else passes++;
      checks++; if (kp_if.key !== 4'h0) $display("FAIL reset_key got=%h exp=0", kp_if.key); else passes++;
      checks++; if (kp_if.key_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", kp_if.key_valid); else passes++;
      checks++; if (kp_if.key_held !== 1'b0) $display("FAIL reset_held got=%b exp=0", kp_if.key_held); else passes++;
      checks++; if (kp_if.add !== 1'b0) $display("FAIL reset_add got=%b exp=0", kp_if.add); else passes++;
      rst = 1'b0;
      step(3);
      checks++; if (kp_if.row_n !== 4'b1110) $display("FAIL row_before_tick got=%b exp=1110", kp_if.row_n); else passes++;
      step(1);
      checks++; if (kp_if.row_n !== 4'b1101) $display("FAIL row_first_tick got=%b exp=1101", kp_if.row_n); else passes++;
   endtask

   task automatic test_clean_press();
      int         fall;
      logic [3:0] row_at_fall;
      vcount  = 0;
      pressed = 16'h0200;
      step(40);
      checks++; if (vcount !== 1) $display("FAIL clean_strobes got=%0d exp=1", vcount); else passes++;
      checks++; if (last_key !== 4'h9) $display("FAIL clean_key got=%h exp=9", last_key); else passes++;
      checks++; if (held_at_pulse !== 1'b1) $display("FAIL clean_held_with_valid got=%b exp=1", held_at_pulse); else passes++;
      checks++; if (kp_if.key_held !== 1'b1) $display("FAIL clean_held_level got=%b exp=1", kp_if.key_held); else passes++;
      pressed     = 16'h0000;
      fall        = 0;
      row_at_fall = 4'bxxxx;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (fall == 0 && kp_if.key_held === 1'b0) begin
            fall        = i;
            row_at_fall = kp_if.row_n;
         end
      end
      checks++; if (fall < 11 || fall > 14) $display("FAIL release_latency got=%0d exp=11..14", fall); else passes++;
      checks++; if (row_at_fall !== 4'b0111) $display("FAIL release_row_adv got=%b exp=0111", row_at_fall); else passes++;
      checks++; if (vcount !== 1) $display("FAIL no_auto_repeat got=%0d exp=1", vcount); else passes++;
   endtask

   task automatic test_bounce();
      bit ok;
      vcount = 0;
      wait_row_entry(4'b1011, ok);
      checks++; if (ok !== 1'b1) $display("FAIL bounce_wait_row got=%b exp=1", ok); else passes++;
      pressed = 16'h0200;
      step(4);
      checks++; if (kp_if.row_n !== 4'b1011) $display("FAIL bounce_row_frozen got=%b exp=1011", kp_if.row_n); else passes++;
      pressed = 16'h0000;
      step(4);
      checks++; if (kp_if.row_n !== 4'b0111) $display("FAIL bounce_row_adv got=%b exp=0111", kp_if.row_n); else passes++;
      checks++; if (vcount !== 0) $display("FAIL bounce_first_contact got=%0d exp=0", vcount); else passes++;
      pressed = 16'h0200;
      step(60);
      checks++; if (vcount !== 1) $display("FAIL bounce_strobes got=%0d exp=1", vcount); else passes++;
      checks++; if (last_key !== 4'h9) $display("FAIL bounce_key got=%h exp=9", last_key); else passes++;
      pressed = 16'h0000;
      step(24);
   endtask

   task automatic test_add_key();
      vcount  = 0;
      pressed = 16'h0400;
      step(40);
      checks++; if (vcount !== 1) $display("FAIL add1_strobes got=%0d exp=1", vcount); else passes++;
      checks++; if (kp_if.key !== 4'hA) $display("FAIL add1_key got=%h exp=a", kp_if.key); else passes++;
      checks++; if (kp_if.add !== 1'b1) $display("FAIL add1_level got=%b exp=1", kp_if.add); else passes++;
      pressed = 16'h0000;
      step(24);
      vcount  = 0;
      pressed = 16'h0400;
      step(40);
      checks++; if (vcount !== 1) $display("FAIL add2_strobes got=%0d exp=1", vcount); else passes++;
      checks++; if (kp_if.key !== 4'hA) $display("FAIL add2_key got=%h exp=a", kp_if.key); else passes++;
      checks++; if (kp_if.add !== 1'b0) $display("FAIL add2_level got=%b exp=0", kp_if.add); else passes++;
      pressed = 16'h0000;
      step(24);
   endtask

   task automatic test_multi_column();
      int         rot;
      logic [3:0] prev;
      vcount  = 0;
      rot     = 0;
      pressed = 16'h0030;
      prev    = kp_if.row_n;
      for (int i = 0; i < 64; i++) begin
         step(1);
         if (kp_if.row_n !== prev) rot++;
         prev = kp_if.row_n;
      end
      checks++; if (vcount !== 0) $display("FAIL multi_strobes got=%0d exp=0", vcount); else passes++;
      checks++; if (rot !== 16) $display("FAIL multi_rotations got=%0d exp=16", rot); else passes++;
      pressed = 16'h0008;
      step(40);
      checks++; if (vcount !== 1) $display("FAIL multi_after_strobes got=%0d exp=1", vcount); else passes++;
      checks++; if (last_key !== 4'h3) $display("FAIL multi_after_key got=%h exp=3", last_key); else passes++;
      pressed = 16'h0000;
      step(24);
   endtask

   task automatic test_reset_mid_press();
      bit ok;
      wait_row_entry(4'b1011, ok);
      checks++; if (ok !== 1'b1) $display("FAIL mid_wait_row got=%b exp=1", ok); else passes++;
      pressed = 16'h0200;
      step(5);
      checks++; if (kp_if.row_n !== 4'b1011) $display("FAIL mid_debounce_frozen got=%b exp=1011", kp_if.row_n); else passes++;
      rst     = 1'b1;
      pressed = 16'h0000;
      step(1);
      checks++; if (kp_if.row_n !== 4'b1110) $display("FAIL rst_deb_row got=%b exp=1110", kp_if.row_n); else passes++;
      checks++; if (kp_if.key !== 4'h0) $display("FAIL rst_deb_key got=%h exp=0", kp_if.key); else passes++;
      checks++; if (kp_if.key_valid !== 1'b0) $display("FAIL rst_deb_valid got=%b exp=0", kp_if.key_valid); else passes++;
      rst    = 1'b0;
      vcount = 0;
      step(40);
      checks++; if (vcount !== 0) $display("FAIL rst_deb_no_strobe got=%0d exp=0", vcount); else passes++;

      pressed = 16'h0400;
      step(40);
      checks++; if (kp_if.key_held !== 1'b1) $display("FAIL mid_hold_held got=%b exp=1", kp_if.key_held); else passes++;
      checks++; if (kp_if.add !== 1'b1) $display("FAIL mid_hold_add got=%b exp=1", kp_if.add); else passes++;
      rst     = 1'b1;
      pressed = 16'h0000;
      step(1);
      checks++; if (kp_if.add !== 1'b0) $display("FAIL rst_hold_add got=%b exp=0", kp_if.add); else passes++;
      checks++; if (kp_if.key !== 4'h0) $display("FAIL rst_hold_key got=%h exp=0", kp_if.key); else passes++;
      checks++; if (kp_if.key_held !== 1'b0) $display("FAIL rst_hold_held got=%b exp=0", kp_if.key_held); else passes++;
      checks++; if (kp_if.row_n !== 4'b1110) $display("FAIL rst_hold_row got=%b exp=1110", kp_if.row_n); else passes++;
      rst    = 1'b0;
      vcount = 0;
      step(40);
      checks++; if (vcount !== 0) $display("FAIL rst_hold_no_strobe got=%0d exp=0", vcount); else passes++;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_add_key();
      test_multi_column();
      test_reset_mid_press();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
